bcd2bin_serial: RTL and testbench
=================================

# bcd2bin_serial

Serial BCD-to-binary converter. It is the decoding counterpart of the team's serial binary-to-BCD converter, using reverse double-dabble: shift right, then subtract 3 from any BCD digit ≥ 8. It accepts a packed multi-digit BCD word over a valid/ready handshake and returns the binary value after one iteration per BCD bit. It sits on the display/keypad data path, wherever decimal-entered values return to binary arithmetic.

## Interface
Parameters:
- DIGITS, 2, number of packed BCD digits (≥1); data width N = 4*DIGITS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- in_valid  in  1  bcd_in is valid.
- in_ready  out  1  block can accept bcd_in this cycle.
- bcd_in  in  N  packed BCD; digit k is bits [4k+3:4k], and digit 0 is the least significant.
- out_valid  out  1  bin_out and err are valid.
- out_ready  in  1  consumer takes the result.
- bin_out  out  N  binary result, zero-extended to N bits.
- err  out  1  an input digit was greater than 9 (only when BCD2BIN_CHECK_EN is defined).

## Operation
- Internal state is a 2N-bit shift register {bcd_sr[N-1:0], bin_sr[N-1:0]} plus a step counter cnt of width $clog2(N+1).
- FSM states:
  - IDLE: in_ready=1. On in_valid, load bcd_sr=bcd_in, bin_sr=0, cnt=0, latch the error check, then go to SHIFT.
  - SHIFT: each cycle, shift {bcd_sr,bin_sr} right by 1, then in the same cycle apply to every 4-bit digit of bcd_sr: if digit ≥ 8, digit -= 3. Increment cnt. After the step with cnt==N-1, go to DONE.
  - DONE: out_valid=1, bin_out=bin_sr. If out_ready, go to IDLE, unless a new input is taken the same cycle (see below).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Simultaneous events:
  - DONE with out_ready and in_valid: the result is consumed and the new input is loaded on the same edge; next state is SHIFT.
  - DONE with out_ready=0: bin_out and err are held stable. in_valid is ignored.
- Arithmetic: the adjust step is an unsigned 4-bit subtract. After the shift, a valid digit never exceeds 12, so the subtract never wraps.
- After N steps, bcd_sr is all zero and bin_sr holds the value.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, bin_out=0, err=0, cnt=0, shift register=0.
- Latency: if the accept edge is E0, the shift steps occur at E1..EN. out_valid is high in the cycle after EN, i.e. N cycles after acceptance (8 cycles for DIGITS=2).
- Throughput: one conversion every N+1 cycles with back-to-back handshakes.
- Reset asserted mid-SHIFT or in DONE: the block returns to IDLE immediately and the in-flight result is discarded; out_valid falls asynchronously.
- Outputs are registered; there is no combinational path from in_valid to out_valid.

## Configuration
- BCD2BIN_CHECK_EN defined:
  - At acceptance, each digit of bcd_in is compared against 9. If any digit is > 9, err is latched to 1.
  - The conversion still runs its full N cycles, so latency is unchanged.
  - With err=1, bin_out is forced to 0 in DONE.
- BCD2BIN_CHECK_EN undefined:
  - err is tied to 0 and no comparators are built.
  - Invalid digits produce an unspecified bin_out. Sourcing only valid BCD is the upstream's responsibility.

## Structure
- Package bcd_pkg holds:
  - DIGIT_W=4, ADJ_THRESH=4'd8, ADJ_VAL=4'd3;
  - the FSM state typedef (IDLE, SHIFT, DONE);
  - a function returning N for a given DIGITS.
- Sub-module bcd2bin_digit_adj: a 4-bit combinational "if ≥8 subtract 3" stage, instantiated DIGITS times in a generate loop.
- Top level holds the FSM, counter, shift register, error latch and handshake logic.

## Test plan
All scenarios use DIGITS=2.
- Reset: hold rst for 3 cycles mid-conversion → out_valid=0, bin_out=0, in_ready=1 immediately; bcd_in=8'h25 applied after reset → bin_out=8'h19 (25) 8 cycles later.
- Single conversions, with out_ready=1:
  - 8'h99 → 8'h63
  - 8'h42 → 8'h2A
  - 8'h00 → 8'h00
  - 8'h10 → 8'h0A
- Exhaustive: all 100 valid inputs 8'h00..8'h99, compared against a reference model; latency is exactly 8 cycles on every transaction.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → bin_out stable, in_ready=0, a presented in_valid is not accepted. Raise out_ready together with in_valid (8'h07) → same-edge hand-off, next result 8'h07.
- Error path, with BCD2BIN_CHECK_EN defined: 8'h1A → err=1, bin_out=0. The next input 8'h11 → err=0, bin_out=8'h0B.
- Reset mid-SHIFT: assert rst at step 4 of converting 8'h77 → no out_valid follows, and the next conversion is unaffected.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and width helper for the serial BCD-to-binary converter.
package bcd_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam logic [3:0]  ADJ_THRESH = 4'd8;
    localparam logic [3:0]  ADJ_VAL    = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Packed data width for a given number of BCD digits.
    function automatic int unsigned data_width(input int unsigned digits);
        return digits * DIGIT_W;
    endfunction

endpackage

// File: rtl/bcd2bin_serial_if.sv
// Valid/ready bundle between a BCD source/result sink and bcd2bin_serial.
// master: the client that supplies BCD and consumes results; slave: the converter.
interface bcd2bin_serial_if
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2
);
    localparam int unsigned N = data_width(DIGITS);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] bcd_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] bin_out;
    logic         err;

    modport master (
        output in_valid,
        output bcd_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bin_out,
        input  err
    );

    modport slave (
        input  in_valid,
        input  bcd_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bin_out,
        output err
    );

endinterface

// File: rtl/bcd2bin_digit_adj.sv
// One reverse double-dabble digit correction: a digit of 8 or more loses 3.
// Valid BCD never exceeds 12 after the shift, so the subtract cannot wrap.
module bcd2bin_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] raw,
    output logic [3:0] adjusted
);

    // Conditional subtract on a single shifted digit.
    always_comb begin
        adjusted = raw;
        if (raw >= ADJ_THRESH) begin
            adjusted = raw - ADJ_VAL;
        end
    end

endmodule

// File: rtl/bcd2bin_serial.sv
// Serial BCD-to-binary converter (reverse double-dabble), one step per BCD bit.
// Optional build macro: BCD2BIN_CHECK_EN enables the invalid-digit error flag;
// with it undefined err is tied low and no comparators exist.
module bcd2bin_serial
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2
)(
    input  logic              clk,
    input  logic              rst,
    bcd2bin_serial_if.slave   bus
);

    localparam int unsigned     N     = data_width(DIGITS);
    localparam int unsigned     CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state;
    logic [N-1:0]     bcd_sr;
    logic [N-1:0]     bin_sr;
    logic [CNT_W-1:0] cnt;
    logic             out_valid_q;
    logic [N-1:0]     bin_out_q;

    logic             in_ready;
    logic             accept;
    logic [N-1:0]     bcd_shifted;
    logic [N-1:0]     bcd_adjusted;
    logic [N-1:0]     bin_next;

    // The shift moves bcd_sr's LSB into the top of bin_sr; digits are corrected after it.
    assign bcd_shifted = {1'b0, bcd_sr[N-1:1]};
    assign bin_next    = {bcd_sr[0], bin_sr[N-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd2bin_digit_adj u_adj (
            .raw      (bcd_shifted[g*DIGIT_W +: DIGIT_W]),
            .adjusted (bcd_adjusted[g*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BCD2BIN_CHECK_EN
    logic err_q;
    logic bad_digit;

    // Flag any incoming digit above 9.
    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bus.bcd_in[k*DIGIT_W +: DIGIT_W] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // Ready in IDLE, or in DONE when the held result is being taken this cycle.
    always_comb begin
        in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
        accept   = bus.in_valid && in_ready;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.bin_out   = bin_out_q;

    // Converter FSM: load on accept, N shift/adjust steps, then hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bcd_sr      <= '0;
            bin_sr      <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            bin_out_q   <= '0;
`ifdef BCD2BIN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else if (accept) begin
            // Also covers the DONE hand-off where the result leaves as new data arrives.
            state       <= SHIFT;
            bcd_sr      <= bus.bcd_in;
            bin_sr      <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
            err_q       <= bad_digit;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                end
                SHIFT: begin
                    bcd_sr <= bcd_adjusted;
                    bin_sr <= bin_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
`ifdef BCD2BIN_CHECK_EN
                        bin_out_q   <= err_q ? '0 : bin_next;
`else
                        bin_out_q   <= bin_next;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_serial.sv
// Self-checking bench for bcd2bin_serial (DIGITS=2) with a decimal reference model.
module tb_bcd2bin_serial;
    import bcd_pkg::*;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned N      = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd2bin_serial_if #(.DIGITS(DIGITS)) bus ();

    bcd2bin_serial #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of a packed BCD word.
    function automatic int bcd_value(input logic [N-1:0] b);
        int v = 0;
        for (int k = DIGITS - 1; k >= 0; k--) v = v * 10 + int'(b[k*4 +: 4]);
        return v;
    endfunction

    // Reference: does any digit exceed 9.
    function automatic logic has_bad_digit(input logic [N-1:0] b);
        for (int k = 0; k < DIGITS; k++) if (b[k*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_err(input logic [N-1:0] b);
`ifdef BCD2BIN_CHECK_EN
        return has_bad_digit(b);
`else
        return 1'b0;
`endif
    endfunction

    task automatic send(input logic [N-1:0] v);
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 30) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 30) check("send_ready_timeout", 32'(guard), 32'd0);
        bus.bcd_in   = v;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 30) begin
            @(posedge clk); #1; cycles++;
        end
    endtask

    // Full transaction with out_ready=1; the result is consumed on the following edge.
    task automatic convert(input string tag, input logic [N-1:0] v,
                           input logic [N-1:0] exp_bin, input logic exp_e);
        int cyc;
        send(v);
        wait_result(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'd8);
        check({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
        check({tag, "_err"}, 32'(bus.err), 32'(exp_e));
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        int seen;
        logic [N-1:0] b;
        int v;

        bus.in_valid  = 1'b0;
        bus.bcd_in    = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_bin_out", 32'(bus.bin_out), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed conversions.
        convert("d99", 8'h99, 8'h63, 1'b0);
        convert("d42", 8'h42, 8'h2A, 1'b0);
        convert("d00", 8'h00, 8'h00, 1'b0);
        convert("d10", 8'h10, 8'h0A, 1'b0);

        // Reset held 3 cycles mid-conversion: outputs drop immediately.
        send(8'h55);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_bin_out", 32'(bus.bin_out), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        convert("after_rst_25", 8'h25, 8'h19, 1'b0);

        // All valid two-digit inputs against the model.
        for (int i = 0; i < 100; i++) begin
            b = {4'(i / 10), 4'(i % 10)};
            convert("exh", b, 8'(bcd_value(b)), 1'b0);
        end

        // Random valid inputs.
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < DIGITS; k++) b[k*4 +: 4] = 4'($urandom_range(9));
            convert("rnd", b, 8'(bcd_value(b)), 1'b0);
        end

        // Backpressure: result held, input ignored, then same-edge hand-off.
        bus.out_ready = 1'b0;
        send(8'h56);
        wait_result(cyc);
        check("bp_latency", 32'(cyc), 32'd8);
        check("bp_bin", 32'(bus.bin_out), 32'h38);
        bus.bcd_in   = 8'h33;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_bin", 32'(bus.bin_out), 32'h38);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.bcd_in    = 8'h07;
        bus.out_ready = 1'b1;
        #1;
        check("handoff_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("handoff_valid_drop", 32'(bus.out_valid), 32'd0);
        wait_result(cyc);
        check("handoff_latency", 32'(cyc), 32'd8);
        check("handoff_bin", 32'(bus.bin_out), 32'h07);
        @(posedge clk); #1;

`ifdef BCD2BIN_CHECK_EN
        convert("err_1a", 8'h1A, 8'h00, exp_err(8'h1A));
        convert("err_11", 8'h11, 8'h0B, exp_err(8'h11));
`endif

        // Reset after the 4th shift step of 8'h77: no result may appear.
        send(8'h77);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("shiftrst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        check("shiftrst_no_result", 32'(seen), 32'd0);
        b = 8'h31;
        v = bcd_value(b);
        convert("after_shiftrst_31", b, 8'(v), exp_err(b));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
